// File: rtl/shader_load_scheduler_pkg.sv
// Shared types and defaults for the shader program load scheduler.
package shader_pkg;

    localparam int NUM_INSTR_DEFAULT = 12;
    localparam int INSTR_W           = 8;

    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/shader_load_scheduler_sync_fifo.sv
// Synchronous FIFO with occupancy count; a pushed word is visible at the head
// no earlier than the following cycle. clr_i empties it and wins over push/pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       clr_i,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]    level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == LW'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];
    assign level_o = level_q;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH-1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (do_push && !clr_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/shader_load_scheduler.sv
// Buffers SPI instruction words and commits whole programs to shader memory in
// atomic bursts during vblank. Optional flush input via SHADER_SCHED_FLUSH_EN.
module shader_load_scheduler
    import shader_pkg::*;
#(
    parameter int NUM_INSTR = NUM_INSTR_DEFAULT,
    parameter int DEPTH     = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
`ifdef SHADER_SCHED_FLUSH_EN
    input  logic                       flush_i,
`endif
    // A word transfers on a rising edge where instr_valid_i && instr_ready_o;
    // the source must hold instr_i stable while valid is high and ready is low.
    input  instr_t                     instr_i,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    input  logic                       vblank_i,
    input  logic                       exec_busy_i,
    output instr_t                     mem_instr_o,
    output logic                       mem_shift_o,
    output logic                       mem_load_o,
    output logic                       prog_done_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o,
    output logic                       busy_o
);

    localparam int LW = $clog2(DEPTH+1);
    localparam int CW = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ARMED = ARMED;
    localparam logic [1:0] S_BURST = BURST;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          fifo_push, fifo_pop, fifo_clr, fifo_full, fifo_empty;
    logic [LW-1:0] fifo_level;
    instr_t        fifo_dout;
    logic          prog_avail;

    assign prog_avail = (fifo_level >= LW'(NUM_INSTR));

`ifdef SHADER_SCHED_FLUSH_EN
    logic flush_pend_q, flush_pend_d;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fifo_pop = 1'b0;
        fifo_clr = 1'b0;
`ifdef SHADER_SCHED_FLUSH_EN
        flush_pend_d = flush_pend_q;
`endif
        case (state_q)
            S_IDLE:  if (prog_avail) state_d = S_ARMED;
            S_ARMED: if (vblank_i && !exec_busy_i) state_d = S_BURST;
            S_BURST: begin
                // Once started the burst ignores vblank/exec_busy until all words are written.
                fifo_pop = 1'b1;
                if (cnt_q == CW'(NUM_INSTR-1)) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = prog_avail ? S_ARMED : S_IDLE;
        endcase
`ifdef SHADER_SCHED_FLUSH_EN
        // A flush never interrupts a burst; it is held until DONE finishes.
        case (state_q)
            S_IDLE, S_ARMED: if (flush_i) begin
                fifo_clr = 1'b1;
                state_d  = S_IDLE;
            end
            S_BURST: if (flush_i) flush_pend_d = 1'b1;
            default: if (flush_i || flush_pend_q) begin
                fifo_clr     = 1'b1;
                state_d      = S_IDLE;
                flush_pend_d = 1'b0;
            end
        endcase
`endif
    end

    assign fifo_push = instr_valid_i && !fifo_full && !fifo_clr;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
`ifdef SHADER_SCHED_FLUSH_EN
            flush_pend_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef SHADER_SCHED_FLUSH_EN
            flush_pend_q <= flush_pend_d;
`endif
        end
    end

    sync_fifo #(
        .WIDTH (INSTR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clr_i   (fifo_clr),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (instr_i),
        .dout_o  (fifo_dout),
        .level_o (fifo_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr_ready_o = !fifo_full;
    assign level_o       = fifo_level;
    assign busy_o        = (state_q == S_BURST);
    assign mem_shift_o   = (state_q == S_BURST);
    assign mem_load_o    = (state_q == S_BURST);
    assign mem_instr_o   = (state_q == S_BURST) ? fifo_dout : '0;
    assign prog_done_o   = (state_q == S_DONE);

endmodule

// File: tb/tb_shader_load_scheduler.sv
// Directed bench for shader_load_scheduler with a scoreboard of committed words.
module tb_shader_load_scheduler;

    localparam int N = 12;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [7:0] instr_i = '0;
    logic       instr_valid_i = 1'b0;
    logic       instr_ready_o;
    logic       vblank_i = 1'b0;
    logic       exec_busy_i = 1'b0;
    logic [7:0] mem_instr_o;
    logic       mem_shift_o;
    logic       mem_load_o;
    logic       prog_done_o;
    logic [4:0] level_o;
    logic       busy_o;
`ifdef SHADER_SCHED_FLUSH_EN
    logic       flush_i = 1'b0;
`endif

    int         checks = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         waits;
    int         strobes;

    always #5 clk_i = ~clk_i;

    shader_load_scheduler dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
`ifdef SHADER_SCHED_FLUSH_EN
        .flush_i       (flush_i),
`endif
        .instr_i       (instr_i),
        .instr_valid_i (instr_valid_i),
        .instr_ready_o (instr_ready_o),
        .vblank_i      (vblank_i),
        .exec_busy_i   (exec_busy_i),
        .mem_instr_o   (mem_instr_o),
        .mem_shift_o   (mem_shift_o),
        .mem_load_o    (mem_load_o),
        .prog_done_o   (prog_done_o),
        .level_o       (level_o),
        .busy_o        (busy_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives at a negedge; the word is accepted at the next posedge if ready is high.
    task automatic push_word(input logic [7:0] w);
        int n = 0;
        instr_i       = w;
        instr_valid_i = 1'b1;
        while (!instr_ready_o && n < 100) begin
            @(negedge clk_i);
            n++;
        end
        if (instr_ready_o) exp_q.push_back(w);
        else chk("push_timeout", 32'd0, 32'd1);
        @(negedge clk_i);
        instr_valid_i = 1'b0;
    endtask

    // Returns at the negedge of the DONE cycle.
    task automatic run_burst(output int w);
        logic [7:0] e;
        w = 0;
        while (!mem_shift_o && w < 200) begin
            @(negedge clk_i);
            w++;
        end
        chk("burst_start", 32'(mem_shift_o), 32'd1);
        for (int i = 0; i < N; i++) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
            chk("burst_shift", 32'(mem_shift_o), 32'd1);
            chk("burst_load", 32'(mem_load_o), 32'd1);
            chk("burst_busy", 32'(busy_o), 32'd1);
            chk("burst_data", 32'(mem_instr_o), 32'(e));
            chk("burst_done_low", 32'(prog_done_o), 32'd0);
            @(negedge clk_i);
        end
        chk("done_pulse", 32'(prog_done_o), 32'd1);
        chk("done_shift", 32'(mem_shift_o), 32'd0);
        chk("done_data", 32'(mem_instr_o), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 32'(instr_ready_o), 32'd1);
        chk("rst_level", 32'(level_o), 32'd0);
        chk("rst_shift", 32'(mem_shift_o), 32'd0);
        chk("rst_load", 32'(mem_load_o), 32'd0);
        chk("rst_done", 32'(prog_done_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_instr", 32'(mem_instr_o), 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // 1: full program buffered outside vblank, then vblank opens
        for (int i = 1; i <= N; i++) push_word(8'(i));
        strobes = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (mem_shift_o || mem_load_o) strobes++;
        end
        chk("t1_no_strobe_armed", 32'(strobes), 32'd0);
        chk("t1_level12", 32'(level_o), 32'd12);
        vblank_i = 1'b1;
        run_burst(waits);
        chk("t1_latency", 32'(waits), 32'd1);
        chk("t1_level_after", 32'(level_o), 32'd0);
        @(negedge clk_i);
        chk("t1_done_once", 32'(prog_done_o), 32'd0);

        // 2: eleven words never commit; the twelfth triggers the burst
        for (int i = 0; i < N - 1; i++) push_word(8'(8'h20 + i));
        strobes = 0;
        repeat (10) begin
            @(negedge clk_i);
            if (mem_shift_o || mem_load_o || prog_done_o) strobes++;
        end
        chk("t2_partial_no_commit", 32'(strobes), 32'd0);
        chk("t2_level11", 32'(level_o), 32'd11);
        push_word(8'h2B);
        run_burst(waits);
        chk("t2_latency", 32'(waits), 32'd2);
        @(negedge clk_i);
        chk("t2_done_once", 32'(prog_done_o), 32'd0);

        // 3: fill to DEPTH, hold a 17th word against backpressure
        vblank_i = 1'b0;
        for (int i = 0; i < 16; i++) push_word(8'($urandom_range(0, 255)));
        chk("t3_level_full", 32'(level_o), 32'd16);
        chk("t3_ready_low", 32'(instr_ready_o), 32'd0);
        instr_i       = 8'hEE;
        instr_valid_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            chk("t3_held_ready", 32'(instr_ready_o), 32'd0);
            chk("t3_held_level", 32'(level_o), 32'd16);
        end
        vblank_i = 1'b1;
        fork
            run_burst(waits);
            push_word(8'hEE);
        join
        chk("t3_level_surplus", 32'(level_o), 32'd5);
        @(negedge clk_i);
        chk("t3_idle_after", 32'(prog_done_o | mem_shift_o), 32'd0);

        // 4: exec_busy holds off an armed burst; vblank drop mid-burst is ignored
        vblank_i    = 1'b0;
        exec_busy_i = 1'b1;
        for (int i = 0; i < 7; i++) push_word(8'(8'h40 + i));
        vblank_i = 1'b1;
        strobes = 0;
        repeat (5) begin
            @(negedge clk_i);
            if (mem_shift_o || mem_load_o) strobes++;
        end
        chk("t4_busy_blocks", 32'(strobes), 32'd0);
        chk("t4_level12", 32'(level_o), 32'd12);
        exec_busy_i = 1'b0;
        fork
            run_burst(waits);
            begin
                repeat (4) @(negedge clk_i);
                vblank_i    = 1'b0;
                exec_busy_i = 1'b1;
            end
        join
        chk("t4_latency", 32'(waits), 32'd1);
        chk("t4_level_after", 32'(level_o), 32'd0);
        exec_busy_i = 1'b0;

        // 5: reset at burst cycle 6
        for (int i = 0; i < N; i++) push_word(8'(8'h80 + i));
        vblank_i = 1'b1;
        waits = 0;
        while (!mem_shift_o && waits < 50) begin
            @(negedge clk_i);
            waits++;
        end
        repeat (5) @(negedge clk_i);
        chk("t5_in_burst", 32'(mem_shift_o), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("t5_shift", 32'(mem_shift_o), 32'd0);
        chk("t5_load", 32'(mem_load_o), 32'd0);
        chk("t5_level", 32'(level_o), 32'd0);
        chk("t5_ready", 32'(instr_ready_o), 32'd1);
        chk("t5_done", 32'(prog_done_o), 32'd0);
        rst_ni = 1'b1;
        exp_q.delete();
        strobes = 0;
        repeat (20) begin
            @(negedge clk_i);
            if (mem_shift_o || prog_done_o) strobes++;
        end
        chk("t5_quiet_after", 32'(strobes), 32'd0);
        vblank_i = 1'b0;

`ifdef SHADER_SCHED_FLUSH_EN
        // 6: flush wins over a simultaneous push
        for (int i = 0; i < 8; i++) push_word(8'(8'hA0 + i));
        chk("t6_level8", 32'(level_o), 32'd8);
        flush_i       = 1'b1;
        instr_i       = 8'h55;
        instr_valid_i = 1'b1;
        @(negedge clk_i);
        flush_i       = 1'b0;
        instr_valid_i = 1'b0;
        exp_q.delete();
        chk("t6_level_flushed", 32'(level_o), 32'd0);
        for (int i = 0; i < N; i++) push_word(8'(8'hC0 + i));
        vblank_i = 1'b1;
        run_burst(waits);
        chk("t6_level_after", 32'(level_o), 32'd0);
        vblank_i = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
